// File: rtl/fnd_scan_if.sv
// Scan-bus and decoded-result bundle for the FND display receive path.
// The master drives the scan bus; the slave is the decoder that drives the results back.
interface fnd_scan_if;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;
    logic [13:0] data_out;
    logic        data_valid;
    logic        data_err;
    logic        busy;
    logic        scan_lost;

    modport master (
        output fndCom, fndFont,
        input  data_out, data_valid, data_err, busy, scan_lost
    );

    modport slave (
        input  fndCom, fndFont,
        output data_out, data_valid, data_err, busy, scan_lost
    );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Recovers the 4-digit decimal value shown on a multiplexed common-anode 7-segment scan bus.
// Stable digits fill per-slot registers; a full frame is converted from BCD to binary over 4 cycles.
module fnd_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 250_000
) (
    input  logic         clk,
    input  logic         reset,
    fnd_scan_if.slave    bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {COLLECT, CONV} state_t;

    logic [11:0]   samp_in;
    logic [11:0]   samp_q;
    logic [3:0]    stab_cnt_reg;
    logic          same;
    logic          accept;
    logic [3:0]    slot_hit;
    logic [3:0]    font_digit;
    logic          font_bad;

    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_fire;
    logic          scan_lost_reg;

    logic [15:0]   digits_reg;
    logic [15:0]   digits_next;
    logic [3:0]    err_reg;
    logic [3:0]    err_next;
    logic [3:0]    seen_reg;
    logic [3:0]    seen_next;
    logic          frame_take;
    logic          frame_clear;

    state_t        state_reg;
    logic [15:0]   snap_reg;
    logic          snap_err_reg;
    logic [13:0]   acc_reg;
    logic [13:0]   acc_next;
    logic [1:0]    step_reg;
    logic          busy_reg;
    logic [13:0]   data_out_reg;
    logic          data_valid_reg;
    logic          data_err_reg;

    assign samp_in = {bus.fndCom, bus.fndFont};
    assign same    = (samp_in == samp_q);

    always_comb begin
        slot_hit = 4'b0000;
        case (bus.fndCom)
            4'b1110: slot_hit = 4'b0001;
            4'b1101: slot_hit = 4'b0010;
            4'b1011: slot_hit = 4'b0100;
            4'b0111: slot_hit = 4'b1000;
            default: slot_hit = 4'b0000;
        endcase
    end

    // Fires once per stable window, and only for a single-digit select pattern.
    assign accept = same && (stab_cnt_reg == 4'(STABLE_CYCLES - 1)) && (slot_hit != 4'b0000);

    // Active-low segments, decimal point ignored.
    always_comb begin
        font_digit = 4'd0;
        font_bad   = 1'b0;
        case (bus.fndFont[6:0])
            7'h40: font_digit = 4'd0;
            7'h79: font_digit = 4'd1;
            7'h24: font_digit = 4'd2;
            7'h30: font_digit = 4'd3;
            7'h19: font_digit = 4'd4;
            7'h12: font_digit = 4'd5;
            7'h02: font_digit = 4'd6;
            7'h78: font_digit = 4'd7;
            7'h00: font_digit = 4'd8;
            7'h10: font_digit = 4'd9;
            default: font_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q       <= 12'hFFF;
            stab_cnt_reg <= 4'd0;
        end else begin
            samp_q <= samp_in;
            if (!same)
                stab_cnt_reg <= 4'd1;
            else if (stab_cnt_reg != 4'(STABLE_CYCLES))
                stab_cnt_reg <= stab_cnt_reg + 4'd1;
        end
    end

    // An accept on the same edge suppresses the timeout.
    assign tmo_fire = !accept && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg   <= '0;
            scan_lost_reg <= 1'b0;
        end else if (accept) begin
            tmo_cnt_reg   <= '0;
            scan_lost_reg <= 1'b0;
        end else begin
            if (tmo_cnt_reg != TW'(TIMEOUT_CYCLES))
                tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            if (tmo_fire)
                scan_lost_reg <= 1'b1;
        end
    end

    assign frame_take  = (state_reg == COLLECT) && (seen_reg == 4'hF);
    assign frame_clear = frame_take || tmo_fire;

    // A fresh accept into a slot takes priority over the frame/timeout clear.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign digits_next[gi*4 +: 4] = (accept && slot_hit[gi]) ? font_digit : digits_reg[gi*4 +: 4];
            assign err_next[gi]  = (accept && slot_hit[gi]) ? font_bad : (frame_clear ? 1'b0 : err_reg[gi]);
            assign seen_next[gi] = (accept && slot_hit[gi]) ? 1'b1     : (frame_clear ? 1'b0 : seen_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_reg <= 16'd0;
            err_reg    <= 4'd0;
            seen_reg   <= 4'd0;
        end else begin
            digits_reg <= digits_next;
            err_reg    <= err_next;
            seen_reg   <= seen_next;
        end
    end

    // Snapshot is shifted left each step so the top nibble is always the next digit.
    assign acc_next = (acc_reg * 14'd10) + {10'd0, snap_reg[15:12]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= COLLECT;
            snap_reg       <= 16'd0;
            snap_err_reg   <= 1'b0;
            acc_reg        <= 14'd0;
            step_reg       <= 2'd0;
            busy_reg       <= 1'b0;
            data_out_reg   <= 14'd0;
            data_valid_reg <= 1'b0;
            data_err_reg   <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            case (state_reg)
                COLLECT: begin
                    if (frame_take) begin
                        snap_reg     <= digits_reg;
                        snap_err_reg <= |err_reg;
                        acc_reg      <= 14'd0;
                        step_reg     <= 2'd0;
                        busy_reg     <= 1'b1;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    acc_reg  <= acc_next;
                    snap_reg <= {snap_reg[11:0], 4'd0};
                    step_reg <= step_reg + 2'd1;
                    if (step_reg == 2'd3) begin
                        data_out_reg   <= acc_next;
                        data_err_reg   <= snap_err_reg;
                        data_valid_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= COLLECT;
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.data_err   = data_err_reg;
    assign bus.busy       = busy_reg;
    assign bus.scan_lost  = scan_lost_reg;
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: frame decode, glitch filtering, bad fonts,
// timeout discard, reset during conversion and continuous scanning.
module tb_fnd_scan_decoder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   vcount = 0;
    int   base;
    int   expv;

    logic [7:0] seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_scan_if bus();

    fnd_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.data_valid) begin
            vcount++;
            $display("valid: data_out=%0d data_err=%0d", bus.data_out, bus.data_err);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic put(input logic [3:0] c, input logic [7:0] f, input int n);
        bus.fndCom  = c;
        bus.fndFont = f;
        repeat (n) @(negedge clk);
    endtask

    function automatic int val(input int r);
        return (r % 10) * 1000 + ((r + 1) % 10) * 100 + ((r + 2) % 10) * 10 + ((r + 3) % 10);
    endfunction

    initial begin
        reset       = 1'b1;
        bus.fndCom  = 4'hF;
        bus.fndFont = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst data_out", bus.data_out, 0);
        chk("rst data_valid", bus.data_valid, 0);
        chk("rst data_err", bus.data_err, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst scan_lost", bus.scan_lost, 0);

        // Frame 1234 with cycle-exact timing on the final digit
        put(4'b1110, 8'h99, 6);
        put(4'b1101, 8'hB0, 6);
        put(4'b1011, 8'hA4, 6);
        put(4'b0111, 8'hF9, 4);
        chk("1234 busy before conv", bus.busy, 0);
        @(negedge clk);
        chk("1234 busy edge4", bus.busy, 1);
        repeat (3) @(negedge clk);
        chk("1234 busy edge7", bus.busy, 1);
        chk("1234 valid edge7", bus.data_valid, 0);
        @(negedge clk);
        chk("1234 valid edge8", bus.data_valid, 1);
        chk("1234 data_out", bus.data_out, 1234);
        chk("1234 data_err", bus.data_err, 0);
        chk("1234 busy edge8", bus.busy, 0);
        @(negedge clk);
        chk("1234 valid one cycle", bus.data_valid, 0);
        chk("1234 data_out hold", bus.data_out, 1234);
        put(4'hF, 8'hFF, 2);
        chk("1234 pulse count", vcount, 1);

        // 5678 with a 3-cycle glitch after tens and tens held exactly 4 cycles
        put(4'b1110, 8'h80, 6);
        put(4'b1101, 8'hF8, 4);
        put(4'b1101, 8'hF9, 3);
        put(4'b1011, 8'h82, 6);
        put(4'b0111, 8'h92, 10);
        chk("glitch data_out", bus.data_out, 5678);
        chk("glitch pulse count", vcount, 2);

        // Undecodable hundreds font
        put(4'b1110, 8'h40, 6);
        put(4'b1101, 8'h40, 6);
        put(4'b1011, 8'h88, 6);
        put(4'b0111, 8'h40, 10);
        chk("badfont data_out", bus.data_out, 0);
        chk("badfont data_err", bus.data_err, 1);

        // Nines with decimal point lit
        put(4'b1110, 8'h10, 6);
        put(4'b1101, 8'h10, 6);
        put(4'b1011, 8'h10, 6);
        put(4'b0111, 8'h10, 10);
        chk("dp data_out", bus.data_out, 9999);
        chk("dp data_err", bus.data_err, 0);
        chk("dp pulse count", vcount, 4);

        // Partial frame discarded by timeout
        base = vcount;
        put(4'b1110, 8'hF9, 6);
        chk("partial scan_lost", bus.scan_lost, 0);
        put(4'b1101, 8'hA4, 6);
        put(4'b1011, 8'hB0, 6);
        put(4'hF, 8'hFF, 20);
        chk("timeout scan_lost", bus.scan_lost, 1);
        chk("timeout no valid", vcount, base);
        put(4'b0111, 8'h99, 10);
        chk("timeout recovered", bus.scan_lost, 0);
        chk("timeout discarded", vcount, base);
        put(4'b1110, 8'hF9, 6);
        put(4'b1101, 8'hA4, 6);
        put(4'b1011, 8'hB0, 10);
        chk("4321 data_out", bus.data_out, 4321);
        chk("4321 pulse count", vcount, base + 1);

        // Reset two edges into conversion
        base = vcount;
        put(4'b1110, 8'h80, 6);
        put(4'b1101, 8'h80, 6);
        put(4'b1011, 8'h80, 6);
        put(4'b0111, 8'h80, 6);
        reset       = 1'b1;
        bus.fndCom  = 4'hF;
        bus.fndFont = 8'hFF;
        repeat (2) @(negedge clk);
        chk("midrst data_out", bus.data_out, 0);
        chk("midrst busy", bus.busy, 0);
        chk("midrst data_err", bus.data_err, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst no valid", vcount, base);
        chk("midrst data_out after", bus.data_out, 0);
        put(4'b1110, 8'hF8, 6);
        put(4'b1101, 8'hC0, 6);
        put(4'b1011, 8'hC0, 6);
        put(4'b0111, 8'hC0, 10);
        chk("0007 data_out", bus.data_out, 7);
        chk("0007 pulse count", vcount, base + 1);

        // Continuous rotation, 5-cycle dwell, value changes every rotation
        base = vcount;
        for (int r = 0; r < 10; r++) begin
            put(4'b1110, seg[(r + 3) % 10], 5);
            put(4'b1101, seg[(r + 2) % 10], 5);
            put(4'b1011, seg[(r + 1) % 10], 5);
            put(4'b0111, seg[r % 10], 5);
            chk("scan pulse count", vcount, base + r);
            if (r > 0) begin
                expv = val(r - 1);
                chk("scan data_out", bus.data_out, expv);
            end
        end
        put(4'hF, 8'hFF, 10);
        chk("scan final count", vcount, base + 10);
        expv = val(9);
        chk("scan final data_out", bus.data_out, expv);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
